// File: rtl/ghpi_sram_slave_if.sv
// GHPI request/response bundle between a core port (master) and the SRAM responder (slave).
// Handshake: the master raises valid_i and holds it until it sees ack_o; ack_o is a
// single-cycle completion pulse, and dropping valid_i before ack_o abandons the request.
interface ghpi_sram_slave_if;
    logic        valid_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [3:0]  sel_i;
    logic        we_i;
    logic [31:0] data_o;
    logic        ack_o;

    modport master (
        output valid_i, addr_i, data_i, sel_i, we_i,
        input  data_o, ack_o
    );

    modport slave (
        input  valid_i, addr_i, data_i, sel_i, we_i,
        output data_o, ack_o
    );
endinterface

// File: rtl/ghpi_sram_slave.sv
// Word-organised, byte-writable synchronous RAM answering one GHPI port,
// with a programmable number of wait states before the one-cycle ack.
module ghpi_sram_slave #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 0,
    parameter     INIT_FILE   = ""
) (
    input  logic               clk_i,
    input  logic               rst_i,
    ghpi_sram_slave_if.slave   bus,
    output logic [1:0]         debug_state
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    // debug_state encoding: 0 = IDLE, 1 = WAIT, 2 = RESP
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]            cnt;
    logic [3:0]            cnt_next;
    logic                  capture;
    logic                  access;
    logic                  commit;

    logic [ADDR_WIDTH-1:0] req_idx;
    logic [31:0]           req_data;
    logic [3:0]            req_sel;
    logic                  req_we;

    logic [ADDR_WIDTH-1:0] in_idx;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic [31:0]           acc_data;
    logic [3:0]            acc_sel;
    logic                  acc_we;

    logic [31:0]           rd_data;
    logic [31:0]           mem [DEPTH];

    logic                  unused_addr_bits;

    // Upper address bits never reach the array, so addresses alias by design.
    assign in_idx           = bus.addr_i[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{bus.addr_i[31:ADDR_WIDTH+2], bus.addr_i[1:0]};

    // A zero-wait access happens at the accepting edge, so it must use the live inputs.
    assign acc_idx  = (state == IDLE) ? in_idx         : req_idx;
    assign acc_data = (state == IDLE) ? bus.data_i     : req_data;
    assign acc_sel  = (state == IDLE) ? bus.sel_i      : req_sel;
    assign acc_we   = (state == IDLE) ? bus.we_i       : req_we;
    assign commit   = access && !rst_i;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        access     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.valid_i) begin
                    capture = 1'b1;
                    if (WAIT_STATES == 0) begin
                        access     = 1'b1;
                        state_next = RESP;
                    end else begin
                        cnt_next   = WAIT_LOAD;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!bus.valid_i) begin
                    cnt_next   = 4'd0;
                    state_next = IDLE;
                end else if (cnt == 4'd0) begin
                    access     = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            req_idx  <= '0;
            req_data <= 32'h0;
            req_sel  <= 4'h0;
            req_we   <= 1'b0;
            rd_data  <= 32'h0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (capture) begin
                req_idx  <= in_idx;
                req_data <= bus.data_i;
                req_sel  <= bus.sel_i;
                req_we   <= bus.we_i;
            end
            if (access && !acc_we) begin
                rd_data <= mem[acc_idx];
            end
        end
    end

    // Array has no reset so it maps onto block RAM; contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (commit && acc_we) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_sel[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_data[8*b +: 8];
                end
            end
        end
    end

    assign bus.data_o  = rd_data;
    assign bus.ack_o   = (state == RESP);
    assign debug_state = state;

endmodule
